// File: rtl/stage3_pkg.sv
// Shared constants and micro-op encodings for the stage-3 write/branch block.
package stage3_pkg;
  typedef enum logic [2:0] {
    MB_NOP        = 3'd0,
    MB_RAM_WR     = 3'd1,
    MB_IO_WR      = 3'd2,
    MB_RAM_WR_IND = 3'd3,
    MB_JMP        = 3'd4,
    MB_JZ         = 3'd5,
    MB_JNZ        = 3'd6,
    MB_HALT       = 3'd7
  } mblock_e;

  localparam logic [15:0] RESET_PC = 16'h0044;
  localparam logic [15:0] PC_STEP  = 16'd4;
endpackage

// File: rtl/stage3_pc_next.sv
// Next-PC selection: reset vector, hold while powered off, jumps, or increment.
module stage3_pc_next
  import stage3_pkg::*;
(
  input  logic        rst,
  input  logic        reset_button,
  input  logic        is_powered_on,
  input  mblock_e     mblock,
  input  logic        flag_last_zero,
  input  logic [15:0] pc,
  input  logic [15:0] target,
  output logic [15:0] pc_next
);
  logic [15:0] pc_inc;
  logic        take_jump;

  always_comb begin
    pc_inc    = pc + PC_STEP;
    take_jump = (mblock == MB_JMP) ||
                ((mblock == MB_JZ)  &&  flag_last_zero) ||
                ((mblock == MB_JNZ) && !flag_last_zero);
    if (rst || reset_button)  pc_next = RESET_PC;
    else if (!is_powered_on)  pc_next = pc;
    else if (take_jump)       pc_next = target;
    else                      pc_next = pc_inc;
  end
endmodule

// File: rtl/stage3.sv
// Stage 3: combinational write decode, power-state update and next-PC selection.
module stage3
  import stage3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mblock_s3,
  input  logic [31:0] vrw_value,
  input  logic [31:0] vw_value,
  input  logic [7:0]  vrw_source,
  input  logic [15:0] pc,
  input  logic        is_powered_on,
  input  logic        flag_last_zero,
  input  logic        execute_from_ram,
  input  logic        reset_button,
  output logic [31:0] output_devices_value,
  output logic [7:0]  io_device_id,
  output logic [15:0] ram_address,
  output logic [31:0] ram_in,
  output logic        ram_is_write,
  output logic        output_is_write,
  output logic [15:0] pc_next,
  output logic        execute_from_ram_new,
  output logic        is_powered_on_new
);
  mblock_e mb;
  assign mb = mblock_e'(mblock_s3);

  // No state lives here; rst only takes effect through downstream registers.
  logic unused_sigs;
  assign unused_sigs = &{1'b0, clk, vrw_value[31:16]};

  stage3_pc_next u_pc_next (
    .rst            (rst),
    .reset_button   (reset_button),
    .is_powered_on  (is_powered_on),
    .mblock         (mb),
    .flag_last_zero (flag_last_zero),
    .pc             (pc),
    .target         (vw_value[15:0]),
    .pc_next        (pc_next)
  );

  always_comb begin
    output_devices_value = '0;
    io_device_id         = '0;
    ram_address          = '0;
    ram_in               = '0;
    ram_is_write         = 1'b0;
    output_is_write      = 1'b0;
    is_powered_on_new    = is_powered_on;
    execute_from_ram_new = execute_from_ram;
    if (rst || reset_button) begin
      is_powered_on_new    = 1'b1;
      execute_from_ram_new = 1'b0;
    end else if (is_powered_on) begin
      unique case (mb)
        MB_RAM_WR: begin
          ram_is_write = 1'b1;
          ram_address  = {8'd0, vrw_source};
          ram_in       = vw_value;
        end
        MB_IO_WR: begin
          output_is_write      = 1'b1;
          io_device_id         = vrw_source;
          output_devices_value = vw_value;
        end
        MB_RAM_WR_IND: begin
          ram_is_write = 1'b1;
          ram_address  = vrw_value[15:0];
          ram_in       = vw_value;
        end
        MB_HALT: is_powered_on_new = 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stage3.sv
// Directed and randomized checks of stage3 against a behavioural model.
module tb_stage3;
  logic        clk = 1'b0;
  logic        rst, is_powered_on, flag_last_zero, execute_from_ram, reset_button;
  logic [2:0]  mblock_s3;
  logic [31:0] vrw_value, vw_value;
  logic [7:0]  vrw_source;
  logic [15:0] pc;
  logic [31:0] output_devices_value, ram_in;
  logic [7:0]  io_device_id;
  logic [15:0] ram_address, pc_next;
  logic        ram_is_write, output_is_write, execute_from_ram_new, is_powered_on_new;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage3 dut (
    .clk(clk), .rst(rst), .mblock_s3(mblock_s3), .vrw_value(vrw_value),
    .vw_value(vw_value), .vrw_source(vrw_source), .pc(pc),
    .is_powered_on(is_powered_on), .flag_last_zero(flag_last_zero),
    .execute_from_ram(execute_from_ram), .reset_button(reset_button),
    .output_devices_value(output_devices_value), .io_device_id(io_device_id),
    .ram_address(ram_address), .ram_in(ram_in), .ram_is_write(ram_is_write),
    .output_is_write(output_is_write), .pc_next(pc_next),
    .execute_from_ram_new(execute_from_ram_new), .is_powered_on_new(is_powered_on_new)
  );

  typedef struct {
    int unsigned odv, io_id, raddr, rin, rwe, owe, pcn, efr, pwr;
  } exp_t;

  // Reference: written from the behavioural rules, not from the RTL structure.
  function automatic exp_t model();
    exp_t e;
    int unsigned m = mblock_s3;
    bit jump;
    e = '{default: 0};
    e.efr = execute_from_ram;
    e.pwr = is_powered_on;
    if (rst || reset_button) begin
      e.pcn = 'h44; e.pwr = 1; e.efr = 0;
    end else if (!is_powered_on) begin
      e.pcn = pc;
    end else begin
      jump  = (m == 4) || (m == 5 && flag_last_zero) || (m == 6 && !flag_last_zero);
      e.pcn = jump ? (vw_value % 65536) : ((pc + 4) % 65536);
      if (m == 1) begin e.rwe = 1; e.raddr = vrw_source; e.rin = vw_value; end
      if (m == 3) begin e.rwe = 1; e.raddr = vrw_value % 65536; e.rin = vw_value; end
      if (m == 2) begin e.owe = 1; e.io_id = vrw_source; e.odv = vw_value; end
      if (m == 7) e.pwr = 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    exp_t e = model();
    chk({tag, ".odv"},   output_devices_value, e.odv);
    chk({tag, ".io_id"}, {24'd0, io_device_id}, e.io_id);
    chk({tag, ".raddr"}, {16'd0, ram_address}, e.raddr);
    chk({tag, ".rin"},   ram_in, e.rin);
    chk({tag, ".rwe"},   {31'd0, ram_is_write}, e.rwe);
    chk({tag, ".owe"},   {31'd0, output_is_write}, e.owe);
    chk({tag, ".pcn"},   {16'd0, pc_next}, e.pcn);
    chk({tag, ".efr"},   {31'd0, execute_from_ram_new}, e.efr);
    chk({tag, ".pwr"},   {31'd0, is_powered_on_new}, e.pwr);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1; mblock_s3 = 3'd1; vrw_value = 97; vw_value = 99; vrw_source = 15;
    pc = 10; is_powered_on = 1; flag_last_zero = 0; execute_from_ram = 1; reset_button = 0;
    settle();
    chk("rst.rwe", {31'd0, ram_is_write}, 0);
    chk("rst.pcn", {16'd0, pc_next}, 32'h44);
    chk("rst.pwr", {31'd0, is_powered_on_new}, 1);
    chk("rst.efr", {31'd0, execute_from_ram_new}, 0);
    chk("rst.raddr", {16'd0, ram_address}, 0);
    chk_all("rst");

    rst = 0; mblock_s3 = 3'd0; settle();
    chk("nop.pcn", {16'd0, pc_next}, 14);
    chk("nop.rwe", {31'd0, ram_is_write}, 0);
    chk("nop.owe", {31'd0, output_is_write}, 0);

    mblock_s3 = 3'd1; settle();
    chk("ramwr.addr", {16'd0, ram_address}, 15);
    chk("ramwr.in", ram_in, 99);
    chk("ramwr.we", {31'd0, ram_is_write}, 1);
    chk("ramwr.pcn", {16'd0, pc_next}, 14);

    mblock_s3 = 3'd2; settle();
    chk("io.id", {24'd0, io_device_id}, 15);
    chk("io.val", output_devices_value, 99);
    chk("io.we", {31'd0, output_is_write}, 1);
    chk("io.rwe", {31'd0, ram_is_write}, 0);

    mblock_s3 = 3'd3; settle();
    chk("ind.addr", {16'd0, ram_address}, 97);
    chk("ind.in", ram_in, 99);
    chk("ind.we", {31'd0, ram_is_write}, 1);
    chk("ind.owe", {31'd0, output_is_write}, 0);

    mblock_s3 = 3'd4; settle(); chk("jmp", {16'd0, pc_next}, 99);
    mblock_s3 = 3'd5; flag_last_zero = 1; settle(); chk("jz.t", {16'd0, pc_next}, 99);
    flag_last_zero = 0; settle(); chk("jz.n", {16'd0, pc_next}, 14);
    mblock_s3 = 3'd6; settle(); chk("jnz.t", {16'd0, pc_next}, 99);
    flag_last_zero = 1; settle(); chk("jnz.n", {16'd0, pc_next}, 14);

    mblock_s3 = 3'd7; execute_from_ram = 1; settle();
    chk("halt.pwr", {31'd0, is_powered_on_new}, 0);
    chk("halt.efr", {31'd0, execute_from_ram_new}, 1);
    chk("halt.pcn", {16'd0, pc_next}, 14);

    reset_button = 1; is_powered_on = 0; settle();
    chk("rb.pcn", {16'd0, pc_next}, 32'h44);
    chk("rb.pwr", {31'd0, is_powered_on_new}, 1);
    chk("rb.efr", {31'd0, execute_from_ram_new}, 0);

    reset_button = 0; mblock_s3 = 3'd1; settle();
    chk("off.pcn", {16'd0, pc_next}, 10);
    chk("off.rwe", {31'd0, ram_is_write}, 0);
    chk("off.pwr", {31'd0, is_powered_on_new}, 0);

    is_powered_on = 1; pc = 16'hFFFC; mblock_s3 = 3'd0; settle();
    chk("wrap.pcn", {16'd0, pc_next}, 0);

    rst = 1; mblock_s3 = 3'd2; settle();
    chk("rst.owe", {31'd0, output_is_write}, 0);
    rst = 0; settle();
    chk("rst_rel.owe", {31'd0, output_is_write}, 1);

    for (int i = 0; i < 300; i++) begin
      rst              = ($urandom_range(0, 9) == 0);
      reset_button     = ($urandom_range(0, 9) == 0);
      is_powered_on    = ($urandom_range(0, 4) != 0);
      mblock_s3        = 3'($urandom_range(0, 7));
      vrw_value        = $urandom;
      vw_value         = $urandom;
      vrw_source       = 8'($urandom);
      pc               = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom);
      flag_last_zero   = 1'($urandom);
      execute_from_ram = 1'($urandom);
      settle();
      chk_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
